// File: rtl/store_buffer_if.sv
// Bundles the buffer's pipeline-side and RAM-side signals.
// The slave modport is the store buffer; master is the surrounding pipeline and RAM.
interface store_buffer_if #(
   parameter int unsigned MEM_WIDTH = 32,
   parameter int unsigned MEM_SIZE  = 256
);
   localparam int unsigned AW = $clog2(MEM_SIZE);

   // pipeline side
   logic [AW-1:0]        mem_addr;
   logic                 mem_read_en;
   logic                 mem_write_en;
   logic [MEM_WIDTH-1:0] mem_write_val;
   logic [MEM_WIDTH-1:0] mem_read_val;
   logic                 stall;
   logic                 flush;
   logic                 empty;

   // RAM side
   logic [AW-1:0]        ram_addr;
   logic                 ram_read_en;
   logic                 ram_write_en;
   logic [MEM_WIDTH-1:0] ram_write_val;
   logic [MEM_WIDTH-1:0] ram_read_val;
   logic                 ram_ready;

   modport slave (
      input  mem_addr, mem_read_en, mem_write_en, mem_write_val, flush,
      input  ram_read_val, ram_ready,
      output mem_read_val, stall, empty,
      output ram_addr, ram_read_en, ram_write_en, ram_write_val
   );

   modport master (
      output mem_addr, mem_read_en, mem_write_en, mem_write_val, flush,
      output ram_read_val, ram_ready,
      input  mem_read_val, stall, empty,
      input  ram_addr, ram_read_en, ram_write_en, ram_write_val
   );
endinterface

// File: rtl/store_buffer.sv
// Store buffer between the memory stage and the data RAM.
// Buffers writes in a FIFO, forwards reads from the youngest matching entry,
// and drains to the RAM whenever a read does not need the RAM port.
module store_buffer #(
   parameter int unsigned MEM_WIDTH = 32,
   parameter int unsigned MEM_SIZE  = 256,
   parameter int unsigned DEPTH     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   store_buffer_if.slave     bus
);
   localparam int unsigned AW = $clog2(MEM_SIZE);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0]        r_addr  [DEPTH];
   logic [MEM_WIDTH-1:0] r_data  [DEPTH];
   logic [DEPTH-1:0]     r_valid;
   logic [PW-1:0]        r_head;
   logic [PW-1:0]        r_tail;
   logic [CW-1:0]        r_count;

   logic                 w_hit;
   logic [MEM_WIDTH-1:0] w_hit_data;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_rd_hit;
   logic                 w_rd_miss;
   logic                 w_accept;
   logic                 w_drain;

   // Youngest-match search: walk oldest to youngest so the last match wins.
   always_comb begin
      logic [PW-1:0] idx;
      w_hit      = 1'b0;
      w_hit_data = '0;
      idx        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = r_head + PW'(i);
         if (r_valid[idx] && (r_addr[idx] == bus.mem_addr)) begin
            w_hit      = 1'b1;
            w_hit_data = r_data[idx];
         end
      end
   end

   // Accept, drain and RAM port arbitration; rst_n gates the read path during reset.
   always_comb begin
      w_empty   = (r_count == '0);
      w_full    = (r_count == CW'(DEPTH));
      w_rd_hit  = rst_n & bus.mem_read_en & w_hit;
      w_rd_miss = rst_n & bus.mem_read_en & ~w_hit;
      w_accept  = rst_n & bus.mem_write_en & ~w_full & ~bus.flush;
      w_drain   = rst_n & ~w_empty & bus.ram_ready & ~w_rd_miss;

      bus.stall        = rst_n & bus.mem_write_en & (w_full | bus.flush);
      bus.empty        = w_empty;
      bus.ram_read_en  = w_rd_miss;
      bus.ram_write_en = w_drain;

      bus.mem_read_val = '0;
      if (w_rd_hit)
         bus.mem_read_val = w_hit_data;
      else if (w_rd_miss)
         bus.mem_read_val = bus.ram_read_val;

      bus.ram_addr = '0;
      if (w_rd_miss)
         bus.ram_addr = bus.mem_addr;
      else if (w_drain)
         bus.ram_addr = r_addr[r_head];

      bus.ram_write_val = w_drain ? r_data[r_head] : '0;
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_addr[r_tail]  <= bus.mem_addr;
            r_data[r_tail]  <= bus.mem_write_val;
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + PW'(1);
         end
         if (w_drain) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PW'(1);
         end
         r_count <= r_count + CW'(w_accept) - CW'(w_drain);
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
   localparam int unsigned MW    = 32;
   localparam int unsigned MS    = 256;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } ent_t;

   logic clk;
   logic rst_n;

   store_buffer_if #(.MEM_WIDTH(MW), .MEM_SIZE(MS)) sb_if ();

   store_buffer #(.MEM_WIDTH(MW), .MEM_SIZE(MS), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sb_if)
   );

   logic [31:0] ram_mem [MS];
   logic [31:0] ref_ram [MS];
   ent_t        q [$];
   int          n_vec;
   int          n_bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM: combinational read, write on the clock edge
   assign sb_if.ram_read_val = ram_mem[sb_if.ram_addr];
   always @(posedge clk)
      if (sb_if.ram_write_en) ram_mem[sb_if.ram_addr] <= sb_if.ram_write_val;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      sb_if.mem_read_en   = 1'b0;
      sb_if.mem_write_en  = 1'b0;
      sb_if.mem_addr      = '0;
      sb_if.mem_write_val = '0;
      sb_if.flush         = 1'b0;
      sb_if.ram_ready     = 1'b0;
   endtask

   // One cycle: drive, check outputs against model, then advance the model at the edge.
   task automatic step(input logic re, input logic we, input logic [7:0] a,
                       input logic [31:0] wv, input logic fl, input logic rdy);
      bit          hit, miss, drn, stl, acc;
      logic [31:0] hv, exp_rv, exp_ra, exp_wv;
      @(negedge clk);
      sb_if.mem_read_en   = re;
      sb_if.mem_write_en  = we;
      sb_if.mem_addr      = a;
      sb_if.mem_write_val = wv;
      sb_if.flush         = fl;
      sb_if.ram_ready     = rdy;
      #1;
      hit = 0;
      hv  = '0;
      foreach (q[i]) if (q[i].addr == a) begin hit = 1; hv = q[i].data; end
      miss   = re && !hit;
      exp_rv = !re ? 32'h0 : (hit ? hv : ref_ram[a]);
      stl    = we && ((q.size() == DEPTH) || fl);
      acc    = we && !stl;
      drn    = (q.size() != 0) && rdy && !miss;
      exp_ra = miss ? {24'h0, a} : (drn ? {24'h0, q[0].addr} : 32'h0);
      exp_wv = drn ? q[0].data : 32'h0;
      chk("mem_read_val",  sb_if.mem_read_val, exp_rv);
      chk("ram_read_en",   {31'h0, sb_if.ram_read_en}, {31'h0, miss});
      chk("stall",         {31'h0, sb_if.stall}, {31'h0, stl});
      chk("empty",         {31'h0, sb_if.empty}, {31'h0, q.size() == 0});
      chk("ram_write_en",  {31'h0, sb_if.ram_write_en}, {31'h0, drn});
      chk("ram_addr",      {24'h0, sb_if.ram_addr}, exp_ra);
      chk("ram_write_val", sb_if.ram_write_val, exp_wv);
      @(posedge clk);
      if (drn) begin
         ref_ram[q[0].addr] = q[0].data;
         void'(q.pop_front());
      end
      if (acc) q.push_back('{addr: a, data: wv});
   endtask

   // Async reset pulse landing between edges; outputs must clear immediately.
   task automatic reset_mid_cycle();
      @(negedge clk);
      sb_if.ram_ready    = 1'b1;
      sb_if.mem_read_en  = 1'b1;
      sb_if.mem_write_en = 1'b1;
      sb_if.mem_addr     = 8'h33;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_empty",        {31'h0, sb_if.empty}, 32'h1);
      chk("rst_stall",        {31'h0, sb_if.stall}, 32'h0);
      chk("rst_ram_write_en", {31'h0, sb_if.ram_write_en}, 32'h0);
      chk("rst_ram_read_en",  {31'h0, sb_if.ram_read_en}, 32'h0);
      chk("rst_ram_addr",     {24'h0, sb_if.ram_addr}, 32'h0);
      chk("rst_ram_write_val", sb_if.ram_write_val, 32'h0);
      chk("rst_mem_read_val",  sb_if.mem_read_val, 32'h0);
      q.delete();
      @(posedge clk);
      #1 idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic        h_we;
      logic [7:0]  h_a;
      logic [31:0] h_wv;
      n_vec = 0;
      n_bad = 0;
      for (int i = 0; i < MS; i++) begin
         ram_mem[i] = $urandom;
         ref_ram[i] = ram_mem[i];
      end
      ram_mem[7] = 32'd9;
      ref_ram[7] = 32'd9;
      idle_inputs();
      rst_n = 1'b0;
      #12;
      chk("reset_empty", {31'h0, sb_if.empty}, 32'h1);
      chk("reset_ram_write_en", {31'h0, sb_if.ram_write_en}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // single write drains the next cycle
      step(0, 1, 8'h10, 32'hAAAA0001, 0, 1);
      step(0, 0, 8'h00, 32'h0, 0, 1);
      step(0, 0, 8'h00, 32'h0, 0, 1);

      // forwarding of youngest match, and a miss to RAM
      step(0, 1, 8'h05, 32'd1, 0, 0);
      step(0, 1, 8'h05, 32'd2, 0, 0);
      step(0, 1, 8'h06, 32'd3, 0, 0);
      step(1, 0, 8'h05, 32'h0, 0, 0);
      step(1, 0, 8'h07, 32'h0, 0, 0);

      // fill to full, hold a 5th write while draining
      step(0, 1, 8'h08, 32'd4, 0, 0);
      step(0, 1, 8'h09, 32'd5, 0, 0);
      step(0, 1, 8'h09, 32'd5, 0, 1);
      for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 32'h0, 0, 1);

      // miss reads block draining
      step(0, 1, 8'h20, 32'd20, 0, 0);
      step(0, 1, 8'h21, 32'd21, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 8'h40 + 8'(i), 32'h0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 32'h0, 0, 1);

      // flush with a held write
      step(0, 1, 8'h30, 32'd30, 0, 0);
      step(0, 1, 8'h31, 32'd31, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 8'h32, 32'd32, 1, 1);
      step(0, 1, 8'h32, 32'd32, 0, 1);
      step(0, 0, 8'h00, 32'h0, 0, 1);

      // reset mid-drain with three entries
      step(0, 1, 8'h50, 32'd50, 0, 0);
      step(0, 1, 8'h51, 32'd51, 0, 0);
      step(0, 1, 8'h52, 32'd52, 0, 0);
      step(0, 0, 8'h00, 32'h0, 0, 1);
      reset_mid_cycle();
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 32'h0, 0, 1);
      step(1, 0, 8'h51, 32'h0, 0, 1);

      // random traffic; a stalled write is held until accepted
      h_we = 0; h_a = '0; h_wv = '0;
      for (int c = 0; c < 600; c++) begin
         logic re, fl, rdy, stalled;
         logic [7:0] ra;
         if (!h_we && ($urandom_range(0, 9) < 5)) begin
            h_we = 1;
            h_a  = 8'($urandom_range(0, 7));
            h_wv = $urandom;
         end
         re  = ($urandom_range(0, 9) < 4);
         ra  = 8'($urandom_range(0, 9));
         fl  = ($urandom_range(0, 9) == 0);
         rdy = ($urandom_range(0, 9) < 6);
         stalled = h_we && ((q.size() == DEPTH) || fl);
         step(re, h_we, re ? ra : h_a, h_wv, fl, rdy);
         if (!stalled) h_we = 0;
      end

      // final drain and RAM contents check
      for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 8'h00, 32'h0, 0, 1);
      for (int i = 0; i < MS; i++) chk("ram_contents", ram_mem[i], ref_ram[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
